mod_down_timer: RTL and testbench

Programmable modulo-N down-counter and timer. It counts N-1 down to 0 on each enabled cycle, flags terminal count with a one-cycle done pulse, and then either reloads (periodic mode) or stops and holds (one-shot mode). It is the down-counting, terminal-count-producing counterpart of the team's free-running mod up-counter, and is used for tick generation and timeouts.

---
 rtl/mod_down_timer_pkg.sv | 14 +
 rtl/mod_down_timer.sv | 88 ++++++++
 tb/tb_mod_down_timer.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/mod_down_timer_pkg.sv
// rtl/mod_down_timer_pkg.sv - shared state codes for the down-counting timer family
package mod_down_timer_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_EXPIRED = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        RUN     = ST_RUN,
        EXPIRED = ST_EXPIRED
    } timer_state_e;

endpackage

// File: rtl/mod_down_timer.sv
// rtl/mod_down_timer.sv - programmable modulo-N down-counter with one-shot and periodic modes
module mod_down_timer
    import mod_down_timer_pkg::*;
#(
    parameter int BITS = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            enable,
    input  logic            start,
    input  logic            stop,
    input  logic            auto_reload,
    input  logic [BITS-1:0] period,
    output logic [BITS-1:0] Q,
    output logic            done,
    output logic            busy,
    output logic            expired
);

    timer_state_e    state_q, state_d;
    logic [BITS-1:0] count_q, count_d;
    logic [BITS-1:0] period_q, period_d;
    logic            reload_q, reload_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;
    logic            expired_q, expired_d;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        period_d = period_q;
        reload_d = reload_q;
        done_d   = 1'b0;

        if (stop) begin
            // In IDLE this already matches the current state, so stop is a no-op there.
            state_d = IDLE;
            count_d = '0;
        end else if (start && (period != '0)) begin
            period_d = period;
            reload_d = auto_reload;
            count_d  = period - BITS'(1);
            state_d  = RUN;
        end else if ((state_q == RUN) && enable) begin
            if (count_q != '0) begin
                count_d = count_q - BITS'(1);
            end else begin
                done_d = 1'b1;
                if (reload_q) begin
                    count_d = period_q - BITS'(1);
                end else begin
                    count_d = '0;
                    state_d = EXPIRED;
                end
            end
        end

        // Status flags are registered copies of the next state, so they track state_q exactly.
        busy_d    = (state_d == RUN);
        expired_d = (state_d == EXPIRED);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            count_q   <= '0;
            period_q  <= '0;
            reload_q  <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            period_q  <= period_d;
            reload_q  <= reload_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            expired_q <= expired_d;
        end
    end

    assign Q       = count_q;
    assign done    = done_q;
    assign busy    = busy_q;
    assign expired = expired_q;

endmodule

// File: tb/tb_mod_down_timer.sv
// tb/tb_mod_down_timer.sv - table-driven bench for mod_down_timer
module tb_mod_down_timer;

    localparam int BITS = 4;

    typedef struct {
        logic            en;
        logic            st;
        logic            sp;
        logic            ar;
        logic [BITS-1:0] per;
        logic [BITS-1:0] exp_q;
        logic            exp_done;
        logic            exp_busy;
        logic            exp_expired;
    } vec_t;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            enable;
    logic            start;
    logic            stop;
    logic            auto_reload;
    logic [BITS-1:0] period;
    logic [BITS-1:0] Q;
    logic            done;
    logic            busy;
    logic            expired;

    int passed = 0;
    int total  = 0;
    vec_t vecs[$];

    mod_down_timer #(.BITS(BITS)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .start       (start),
        .stop        (stop),
        .auto_reload (auto_reload),
        .period      (period),
        .Q           (Q),
        .done        (done),
        .busy        (busy),
        .expired     (expired)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic en, input logic st, input logic sp, input logic ar,
                                input int per, input int eq, input logic ed, input logic eb,
                                input logic ee);
        vec_t v;
        v.en = en; v.st = st; v.sp = sp; v.ar = ar; v.per = BITS'(per);
        v.exp_q = BITS'(eq); v.exp_done = ed; v.exp_busy = eb; v.exp_expired = ee;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [BITS-1:0] eq,
                         input logic ed, input logic eb, input logic ee);
        total++;
        if ({Q, done, busy, expired} === {eq, ed, eb, ee}) begin
            passed++;
        end else begin
            $display("FAIL %s[%0d]: got Q=%0d done=%b busy=%b expired=%b, expected Q=%0d done=%b busy=%b expired=%b",
                     name, idx, Q, done, busy, expired, eq, ed, eb, ee);
        end
    endtask

    task automatic drive(input logic en, input logic st, input logic sp, input logic ar,
                         input logic [BITS-1:0] per);
        @(negedge clk);
        enable = en; start = st; stop = sp; auto_reload = ar; period = per;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; enable = 1'b0; start = 1'b0; stop = 1'b0;
        auto_reload = 1'b0; period = '0;

        // en st sp ar per -> Q done busy expired
        vecs.push_back(mk(1, 0, 0, 0, 0,  0, 0, 0, 0));   // idle with enable
        vecs.push_back(mk(1, 1, 0, 0, 0,  0, 0, 0, 0));   // period 0 ignored
        vecs.push_back(mk(1, 1, 0, 0, 4,  3, 0, 1, 0));   // one-shot N=4
        vecs.push_back(mk(1, 0, 0, 0, 0,  2, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0,  1, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0,  0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0,  0, 1, 0, 1));   // terminal -> EXPIRED
        vecs.push_back(mk(1, 0, 0, 0, 0,  0, 0, 0, 1));   // holds, single pulse
        vecs.push_back(mk(0, 0, 1, 0, 0,  0, 0, 0, 0));   // stop from EXPIRED
        vecs.push_back(mk(1, 1, 0, 1, 3,  2, 0, 1, 0));   // periodic N=3
        vecs.push_back(mk(1, 0, 0, 0, 0,  1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,  1, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0,  0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0,  2, 1, 1, 0));   // wrap 0->2 with done
        vecs.push_back(mk(0, 0, 0, 0, 0,  2, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0,  1, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0,  0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0,  0, 0, 0, 0));   // stop beats terminal tick
        vecs.push_back(mk(1, 1, 0, 1, 3,  2, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0,  1, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0,  0, 0, 1, 0));
        vecs.push_back(mk(1, 1, 0, 1, 7,  6, 0, 1, 0));   // start beats terminal tick
        vecs.push_back(mk(1, 1, 0, 1, 1,  0, 0, 1, 0));   // periodic N=1
        vecs.push_back(mk(1, 0, 0, 0, 0,  0, 1, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0,  0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 1, 0));
        vecs.push_back(mk(1, 1, 0, 0, 5,  4, 0, 1, 0));   // mid-run reconfiguration
        vecs.push_back(mk(1, 0, 0, 1, 2,  3, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 1, 2,  2, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0,  2, 0, 1, 0));   // start with period 0 in RUN
        vecs.push_back(mk(1, 1, 0, 0, 2,  1, 0, 1, 0));   // new start reloads
        vecs.push_back(mk(1, 0, 0, 0, 0,  0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0,  0, 1, 0, 1));
        vecs.push_back(mk(1, 0, 1, 0, 0,  0, 0, 0, 0));

        repeat (2) @(posedge clk);
        #1;
        check("reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].en, vecs[i].st, vecs[i].sp, vecs[i].ar, vecs[i].per);
            check("vec", i, vecs[i].exp_q, vecs[i].exp_done, vecs[i].exp_busy, vecs[i].exp_expired);
        end

        // N=15 one-shot: 14 down to 0, then done on the 15th enabled tick
        drive(1, 1, 0, 0, 15);
        check("p15", 0, 14, 0, 1, 0);
        for (int k = 13; k >= 0; k--) begin
            drive(1, 0, 0, 0, 0);
            check("p15", 14 - k, BITS'(k), 0, 1, 0);
        end
        drive(1, 0, 0, 0, 0);
        check("p15", 15, 0, 1, 0, 1);
        drive(0, 0, 1, 0, 0);
        check("p15", 16, 0, 0, 0, 0);

        // asynchronous reset mid-count clears everything without a clock edge
        drive(0, 1, 0, 0, 6);
        check("rst_mid", 0, 5, 0, 1, 0);
        @(negedge clk);
        enable = 1'b0; start = 1'b0;
        #2 reset_n = 1'b0;
        #1 check("rst_mid", 1, 0, 0, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;
        drive(1, 0, 0, 0, 0);
        check("rst_mid", 2, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        check("rst_mid", 3, 0, 0, 0, 0);

        // reset clears an in-flight done pulse
        drive(1, 1, 0, 1, 1);
        drive(1, 0, 0, 0, 0);
        check("rst_done", 0, 0, 1, 1, 0);
        #1 reset_n = 1'b0;
        #1 check("rst_done", 1, 0, 0, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
